// File: rtl/batcharger_adc_sequencer_pkg.sv
// rtl/batcharger_adc_sequencer_pkg.sv - channel codes and sequencer FSM states
package batcharger_pkg;

    localparam logic [1:0] CH_V    = 2'b00;
    localparam logic [1:0] CH_I    = 2'b01;
    localparam logic [1:0] CH_T    = 2'b10;
    localparam logic [1:0] CH_PARK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        START,
        WAIT
    } state_e;

endpackage

// File: rtl/batcharger_adc_sequencer_if.sv
// rtl/batcharger_adc_sequencer_if.sv - charger-controller and ADC-macro signals of the sequencer
interface batcharger_adc_sequencer_if;

    logic       vmonen;
    logic       imonen;
    logic       tmonen;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vvalid;
    logic       ivalid;
    logic       tvalid;
    logic       upd;
    logic       timeout_err;

    modport slave (
        input  vmonen, imonen, tmonen, adc_done, adc_data,
        output adc_sel, adc_start, vbat, ibat, tbat,
        output vvalid, ivalid, tvalid, upd, timeout_err
    );

    modport master (
        output vmonen, imonen, tmonen, adc_done, adc_data,
        input  adc_sel, adc_start, vbat, ibat, tbat,
        input  vvalid, ivalid, tvalid, upd, timeout_err
    );

endinterface

// File: rtl/batcharger_adc_sequencer_rr_arb3.sv
// rtl/batcharger_adc_sequencer_rr_arb3.sv - 3-way round-robin grant V -> I -> T -> V
module batcharger_rr_arb3
    import batcharger_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] gnt_ch_o,
    output logic       gnt_vld_o
);

    logic [3:0] req4;
    logic [1:0] idx;

    assign req4 = {1'b0, req_i};

    // Walk the three channels starting just after the last one served.
    always_comb begin
        gnt_ch_o  = CH_PARK;
        gnt_vld_o = 1'b0;
        idx       = (last_i == CH_PARK) ? CH_T : last_i;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == CH_T) ? CH_V : idx + 2'd1;
            if (!gnt_vld_o && req4[idx]) begin
                gnt_ch_o  = idx;
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/batcharger_adc_sequencer.sv
// rtl/batcharger_adc_sequencer.sv - time-shares one 8-bit ADC across V/I/T monitors
module batcharger_adc_sequencer
    import batcharger_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                       clk,
    input logic                       rst,
    batcharger_adc_sequencer_if.slave bus
);

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_q, sel_d;
    logic       start_q, start_d;
    logic [7:0] vbat_q, vbat_d, ibat_q, ibat_d, tbat_q, tbat_d;
    logic [2:0] valid_q, valid_d;
    logic       upd_q, upd_d;
    logic       terr_q, terr_d;

    logic [2:0] en;
    logic [3:0] en4;
    logic [1:0] gnt_ch;
    logic       gnt_vld;
    logic       done_w, tmo_w, cap_w;

    assign en  = {bus.tmonen, bus.imonen, bus.vmonen};
    assign en4 = {1'b0, en};

    batcharger_rr_arb3 u_arb (
        .req_i     (en),
        .last_i    (last_q),
        .gnt_ch_o  (gnt_ch),
        .gnt_vld_o (gnt_vld)
    );

    // A done coinciding with the last timeout cycle counts as success.
    assign done_w = (state_q == WAIT) && bus.adc_done;
    assign tmo_w  = (state_q == WAIT) && !bus.adc_done && (cnt_q == TIMEOUT_LAST);
    assign cap_w  = done_w && en4[sel_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= CH_T;
            sel_q   <= CH_PARK;
            start_q <= 1'b0;
            vbat_q  <= 8'd0;
            ibat_q  <= 8'd0;
            tbat_q  <= 8'd0;
            valid_q <= 3'b000;
            upd_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            vbat_q  <= vbat_d;
            ibat_q  <= ibat_d;
            tbat_q  <= tbat_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                if (done_w || tmo_w) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        sel_d = sel_q;
        if (state_d == IDLE) begin
            sel_d = CH_PARK;
        end else if (state_q == IDLE) begin
            sel_d = gnt_ch;
        end
        start_d = (state_d == START);
        vbat_d  = vbat_q;
        ibat_d  = ibat_q;
        tbat_d  = tbat_q;
        valid_d = valid_q & en;
        if (cap_w) begin
            case (sel_q)
                CH_V: begin vbat_d = bus.adc_data; valid_d[0] = 1'b1; end
                CH_I: begin ibat_d = bus.adc_data; valid_d[1] = 1'b1; end
                CH_T: begin tbat_d = bus.adc_data; valid_d[2] = 1'b1; end
                default: ;
            endcase
        end
        upd_d  = cap_w;
        terr_d = terr_q | tmo_w;
    end

    assign bus.adc_sel     = sel_q;
    assign bus.adc_start   = start_q;
    assign bus.vbat        = vbat_q;
    assign bus.ibat        = ibat_q;
    assign bus.tbat        = tbat_q;
    assign bus.vvalid      = valid_q[0];
    assign bus.ivalid      = valid_q[1];
    assign bus.tvalid      = valid_q[2];
    assign bus.upd         = upd_q;
    assign bus.timeout_err = terr_q;

endmodule
